// File: rtl/seg7_pkg.sv
// Shared 7-segment code table and helpers used by the hex encoder
// and by the scan decoder.
package seg7_pkg;

  // Active-high gfedcba codes; element k is the glyph for hex digit k.
  localparam logic [15:0][6:0] SEG_CODE = {
    7'h71, 7'h79, 7'h5E, 7'h39,
    7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66,
    7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  localparam logic [6:0] SEG_BLANK = 7'h00;

  function automatic logic onehot_legal(input logic [7:0] v);
    return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
  endfunction

endpackage

// File: rtl/seg7tohex.sv
// Active-low segment pattern to nibble lookup with hit and blank
// indications.
module seg7tohex
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output logic       hit,
  output logic       blank,
  output logic [3:0] nibble
);

  logic [6:0] act;

  always_comb begin
    act    = ~pattern;
    hit    = 1'b0;
    nibble = 4'd0;
    blank  = (act == SEG_BLANK);
    for (int k = 0; k < 16; k++) begin
      if (act == SEG_CODE[k]) begin
        hit    = 1'b1;
        nibble = 4'(k);
      end
    end
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Reconstructs the hex word shown on a multiplexed active-low
// 7-segment bus, with dwell debouncing and bad-pattern flagging.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int NDIGITS       = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NDIGITS-1:0]         an,
  input  logic [6:0]                 segments,
  output logic [4*NDIGITS-1:0]       value,
  output logic                       valid,
  output logic                       err,
  output logic [$clog2(NDIGITS)-1:0] err_digit
);

  localparam int IW = $clog2(NDIGITS);
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CMAX = CW'(STABLE_CYCLES);

  logic [NDIGITS-1:0]   s_an, p_an;
  logic [6:0]           s_seg, p_seg;
  logic [CW-1:0]        cnt, cnt_nx;
  logic                 done, done_nx;
  logic [NDIGITS-1:0]   seen, seen_nx;
  logic [4*NDIGITS-1:0] shadow;

  logic [7:0]    act;
  logic          legal, same, cap, frame;
  logic [IW-1:0] idx;
  logic          hit, blank;
  logic [3:0]    nib;

  seg7tohex u_lut (
    .pattern (s_seg),
    .hit     (hit),
    .blank   (blank),
    .nibble  (nib)
  );

  always_comb begin
    act = '0;
    act[NDIGITS-1:0] = ~s_an;
    legal = onehot_legal(act);
    idx = '0;
    for (int i = 0; i < NDIGITS; i++) begin
      if (act[i]) idx = IW'(i);
    end
    same = legal && (s_an == p_an) && (s_seg == p_seg);
    if (!legal)
      cnt_nx = '0;
    else if (!same)
      cnt_nx = CW'(1);
    else if (cnt == CMAX)
      cnt_nx = cnt;
    else
      cnt_nx = cnt + 1'b1;
    done_nx = same ? done : 1'b0;
    cap = legal && (cnt_nx == CMAX) && !done_nx;
    frame = &seen;
    // A capture landing on the transfer edge keeps its seen bit.
    seen_nx = frame ? '0 : seen;
    if (cap && hit) seen_nx[idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s_an      <= '1;
      s_seg     <= '1;
      p_an      <= '1;
      p_seg     <= '1;
      cnt       <= '0;
      done      <= 1'b0;
      seen      <= '0;
      shadow    <= '0;
      value     <= '0;
      valid     <= 1'b0;
      err       <= 1'b0;
      err_digit <= '0;
    end else begin
      s_an  <= an;
      s_seg <= segments;
      p_an  <= s_an;
      p_seg <= s_seg;
      cnt   <= cnt_nx;
      done  <= cap | done_nx;
      seen  <= seen_nx;
      valid <= frame;
      err   <= cap && !hit && !blank;
      if (cap && !hit && !blank) err_digit <= idx;
      if (frame) value <= shadow;
      if (cap && hit) shadow[4*idx +: 4] <= nib;
    end
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder with hand-computed frames.
module tb_seg7_scan_decoder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  an;
  logic [6:0]  segments;
  logic [15:0] value;
  logic        valid;
  logic        err;
  logic [1:0]  err_digit;

  int tests = 0;
  int failed = 0;

  int vcnt = 0;
  int ecnt = 0;
  logic [15:0] vlast = '0;
  logic [1:0]  elast = '0;

  int v0, e0;

  seg7_scan_decoder #(
    .NDIGITS       (4),
    .STABLE_CYCLES (4)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .an        (an),
    .segments  (segments),
    .value     (value),
    .valid     (valid),
    .err       (err),
    .err_digit (err_digit)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (valid) begin
      vcnt++;
      vlast = value;
    end
    if (err) begin
      ecnt++;
      elast = err_digit;
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Active-low raw segment drive for hex digit n.
  function automatic logic [6:0] seg(input int n);
    logic [6:0] c;
    case (n)
      0:  c = 7'b0111111;
      1:  c = 7'b0000110;
      2:  c = 7'b1011011;
      3:  c = 7'b1001111;
      4:  c = 7'b1100110;
      5:  c = 7'b1101101;
      6:  c = 7'b1111101;
      7:  c = 7'b0000111;
      8:  c = 7'b1111111;
      9:  c = 7'b1101111;
      10: c = 7'b1110111;
      11: c = 7'b1111100;
      12: c = 7'b0111001;
      13: c = 7'b1011110;
      14: c = 7'b1111001;
      default: c = 7'b1110001;
    endcase
    return ~c;
  endfunction

  task automatic dwell(input logic [3:0] a,
                       input logic [6:0] s,
                       input int n);
    an = a;
    segments = s;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    an = 4'hF;
    segments = 7'h7F;
    repeat (3) begin
      an = 4'($urandom());
      segments = 7'($urandom());
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    check("rst_value", 32'(value), 32'h0);
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_err_digit", 32'(err_digit), 32'h0);
    reset_n = 1'b1;
    v0 = vcnt; e0 = ecnt;
    dwell(4'b1111, 7'h7F, 10);
    check("idle_valid", 32'(vcnt - v0), 32'd0);
    check("idle_err", 32'(ecnt - e0), 32'd0);

    // Normal frame 0x1234 with exact valid latency on the last digit.
    v0 = vcnt; e0 = ecnt;
    dwell(4'b1110, seg(4), 8);
    dwell(4'b0111, seg(1), 8);
    dwell(4'b1011, seg(2), 8);
    an = 4'b1101;
    segments = seg(3);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("lat_before", 32'(valid), 32'h0);
    @(posedge clk);
    @(negedge clk);
    check("lat_pulse", 32'(valid), 32'h1);
    check("lat_value", 32'(value), 32'h1234);
    @(negedge clk);
    check("lat_after", 32'(valid), 32'h0);
    dwell(4'b1111, 7'h7F, 6);
    check("norm_count", 32'(vcnt - v0), 32'd1);
    check("norm_value", 32'(vlast), 32'h1234);
    check("norm_err", 32'(ecnt - e0), 32'd0);

    // Glitch on digit 0; remaining dwells exactly STABLE_CYCLES long.
    v0 = vcnt;
    dwell(4'b1110, seg(5), 3);
    dwell(4'b1110, seg(6), 8);
    dwell(4'b1101, seg(7), 4);
    dwell(4'b1011, seg(8), 4);
    dwell(4'b0111, seg(9), 4);
    dwell(4'b1111, 7'h7F, 6);
    check("glitch_count", 32'(vcnt - v0), 32'd1);
    check("glitch_value", 32'(vlast), 32'h9876);

    // A 3-cycle dwell is too short and must not complete a frame.
    v0 = vcnt;
    dwell(4'b1110, seg(1), 4);
    dwell(4'b1101, seg(1), 4);
    dwell(4'b1011, seg(1), 4);
    dwell(4'b0111, seg(1), 3);
    dwell(4'b1111, 7'h7F, 6);
    check("short_dwell", 32'(vcnt - v0), 32'd0);
    dwell(4'b0111, seg(2), 8);
    dwell(4'b1111, 7'h7F, 4);
    check("short_fill", 32'(vcnt - v0), 32'd1);
    check("short_value", 32'(vlast), 32'h2111);

    // Unknown pattern on digit 2.
    v0 = vcnt; e0 = ecnt;
    dwell(4'b1110, seg(5), 8);
    dwell(4'b1101, seg(14), 8);
    dwell(4'b0111, seg(15), 8);
    dwell(4'b1011, 7'b0111111, 8);
    dwell(4'b1111, 7'h7F, 4);
    check("bad_err_count", 32'(ecnt - e0), 32'd1);
    check("bad_err_digit", 32'(elast), 32'd2);
    check("bad_no_valid", 32'(vcnt - v0), 32'd0);
    dwell(4'b1011, seg(12), 8);
    dwell(4'b1111, 7'h7F, 4);
    check("bad_fill", 32'(vcnt - v0), 32'd1);
    check("bad_value", 32'(vlast), 32'hFCE5);

    // Illegal anodes and blank digit 0 must not mark digit 0 seen.
    v0 = vcnt; e0 = ecnt;
    dwell(4'b1101, seg(2), 8);
    dwell(4'b1011, seg(4), 8);
    dwell(4'b0111, seg(8), 8);
    dwell(4'b1100, seg(1), 10);
    dwell(4'b1110, 7'h7F, 10);
    check("ill_no_valid", 32'(vcnt - v0), 32'd0);
    check("ill_no_err", 32'(ecnt - e0), 32'd0);
    dwell(4'b1110, seg(7), 8);
    dwell(4'b1111, 7'h7F, 4);
    check("ill_fill", 32'(vcnt - v0), 32'd1);
    check("ill_value", 32'(vlast), 32'h8427);

    // Reset in mid-frame, then 0xABCD starting from the high digits.
    dwell(4'b1110, seg(1), 8);
    dwell(4'b1101, seg(2), 8);
    an = 4'b1111;
    segments = 7'h7F;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    check("mid_rst_value", 32'(value), 32'h0);
    check("mid_rst_valid", 32'(valid), 32'h0);
    v0 = vcnt; e0 = ecnt;
    dwell(4'b0111, seg(10), 8);
    dwell(4'b1011, seg(11), 8);
    dwell(4'b1101, seg(12), 8);
    dwell(4'b1110, seg(13), 8);
    dwell(4'b1111, 7'h7F, 6);
    check("mid_count", 32'(vcnt - v0), 32'd1);
    check("mid_value", 32'(vlast), 32'hABCD);
    check("mid_err", 32'(ecnt - e0), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
